// File: rtl/pipe_mips32.sv
// pipe_mips32 - five-stage in-order MIPS-like core (IF, ID, EX, MEM, WB).
// Holds one unified word-addressed instruction/data memory and a 32x32
// register file. Both are loaded from outside before reset is released.
// Execution stops for good once a HLT instruction retires.
//
// Ports:
//   clk    - single clock; all state changes on its rising edge
//   rst_n  - asynchronous active-low reset; flushes the pipeline only
//   halted - copy of the internal HALTED flag
//
// Visible internal state: Reg, Mem, PC, HALTED, TAKEN_BRANCH.
module pipe_mips32 #(
  parameter int MEM_WORDS = 1024
) (
  input  logic clk,
  input  logic rst_n,
  output logic halted
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] PC_INC = {{(AW-1){1'b0}}, 1'b1};

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  // Architectural state; Reg and Mem are never cleared by reset.
  logic [31:0]   Reg [0:31];
  logic [31:0]   Mem [0:MEM_WORDS-1];
  logic [AW-1:0] PC;
  logic          HALTED;
  logic          TAKEN_BRANCH;

  // Set once a HLT has been decoded; keeps fetch parked after the HLT
  // has moved past ID. Only a taken older branch can clear it.
  logic          stop_fetch_r;

  // IF/ID
  logic          ifid_valid_r;
  logic [31:0]   ifid_ir_r;
  logic [AW-1:0] ifid_npc_r;

  // ID/EX
  logic [5:0]    idex_op_r;
  logic [4:0]    idex_rs_r, idex_rt_r, idex_dest_r;
  logic [31:0]   idex_a_r, idex_b_r, idex_imm_r;
  logic [AW-1:0] idex_npc_r;
  logic          idex_we_r, idex_memread_r, idex_memwrite_r, idex_branch_r, idex_hlt_r;

  // EX/MEM
  logic [4:0]    exmem_dest_r;
  logic [31:0]   exmem_alu_r, exmem_b_r;
  logic          exmem_we_r, exmem_memread_r, exmem_memwrite_r, exmem_hlt_r;

  // MEM/WB
  logic [4:0]    memwb_dest_r;
  logic [31:0]   memwb_data_r;
  logic          memwb_we_r, memwb_hlt_r;

  // Decode outputs
  logic [5:0]    id_op_s;
  logic [4:0]    id_rs_s, id_rt_s, id_dest_s;
  logic [31:0]   id_imm_s, id_a_s, id_b_s;
  logic          id_we_s, id_memread_s, id_memwrite_s, id_branch_s, id_hlt_s;
  logic          id_use_rs_s, id_use_rt_s;

  logic          ld_use_s, fetch_hold_s, wb_we_s;
  logic [31:0]   ex_a_s, ex_b_s, ex_alu_s, mem_data_s;
  logic          ex_taken_s;
  logic [AW-1:0] ex_target_s, pc_next_s;

  assign halted = HALTED;

  // The register file is written only by a real writer that is not R0,
  // and never once the core has halted.
  assign wb_we_s = memwb_we_r && (memwb_dest_r != 5'd0) && !HALTED;

  // Instruction decode: control bits, destination and register usage.
  always_comb begin
    id_op_s       = ifid_ir_r[31:26];
    id_rs_s       = ifid_ir_r[25:21];
    id_rt_s       = ifid_ir_r[20:16];
    id_imm_s      = {{16{ifid_ir_r[15]}}, ifid_ir_r[15:0]};
    id_dest_s     = 5'd0;
    id_we_s       = 1'b0;
    id_memread_s  = 1'b0;
    id_memwrite_s = 1'b0;
    id_branch_s   = 1'b0;
    id_hlt_s      = 1'b0;
    id_use_rs_s   = 1'b0;
    id_use_rt_s   = 1'b0;
    if (ifid_valid_r) begin
      case (id_op_s)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
          id_we_s     = 1'b1;
          id_dest_s   = ifid_ir_r[15:11];
          id_use_rs_s = 1'b1;
          id_use_rt_s = 1'b1;
        end
        OP_ADDI, OP_SUBI, OP_SLTI: begin
          id_we_s     = 1'b1;
          id_dest_s   = id_rt_s;
          id_use_rs_s = 1'b1;
        end
        OP_LW: begin
          id_we_s      = 1'b1;
          id_memread_s = 1'b1;
          id_dest_s    = id_rt_s;
          id_use_rs_s  = 1'b1;
        end
        OP_SW: begin
          id_memwrite_s = 1'b1;
          id_use_rs_s   = 1'b1;
          id_use_rt_s   = 1'b1;
        end
        OP_BNEQZ, OP_BEQZ: begin
          id_branch_s = 1'b1;
          id_use_rs_s = 1'b1;
        end
        OP_HLT: begin
          id_hlt_s = 1'b1;
        end
        default: begin
          id_we_s = 1'b0;
        end
      endcase
    end else begin
      id_we_s = 1'b0;
    end
  end

  // Register read with write-through of the value retiring in WB.
  always_comb begin
    if (id_rs_s == 5'd0) begin
      id_a_s = 32'd0;
    end else if (wb_we_s && (memwb_dest_r == id_rs_s)) begin
      id_a_s = memwb_data_r;
    end else begin
      id_a_s = Reg[id_rs_s];
    end
    if (id_rt_s == 5'd0) begin
      id_b_s = 32'd0;
    end else if (wb_we_s && (memwb_dest_r == id_rt_s)) begin
      id_b_s = memwb_data_r;
    end else begin
      id_b_s = Reg[id_rt_s];
    end
  end

  // A load in EX cannot forward its data yet; hold a dependent in ID.
  always_comb begin
    if (idex_memread_r && (idex_dest_r != 5'd0) &&
        ((id_use_rs_s && (id_rs_s == idex_dest_r)) ||
         (id_use_rt_s && (id_rt_s == idex_dest_r)))) begin
      ld_use_s = 1'b1;
    end else begin
      ld_use_s = 1'b0;
    end
  end

  // EX operand forwarding; EX/MEM is younger than MEM/WB so it wins.
  // A load in EX/MEM only carries its address, so it is never a source.
  always_comb begin
    if (exmem_we_r && !exmem_memread_r && (exmem_dest_r != 5'd0) && (exmem_dest_r == idex_rs_r)) begin
      ex_a_s = exmem_alu_r;
    end else if (memwb_we_r && (memwb_dest_r != 5'd0) && (memwb_dest_r == idex_rs_r)) begin
      ex_a_s = memwb_data_r;
    end else begin
      ex_a_s = idex_a_r;
    end
    if (exmem_we_r && !exmem_memread_r && (exmem_dest_r != 5'd0) && (exmem_dest_r == idex_rt_r)) begin
      ex_b_s = exmem_alu_r;
    end else if (memwb_we_r && (memwb_dest_r != 5'd0) && (memwb_dest_r == idex_rt_r)) begin
      ex_b_s = memwb_data_r;
    end else begin
      ex_b_s = idex_b_r;
    end
  end

  // ALU and branch resolution.
  always_comb begin
    case (idex_op_r)
      OP_ADD:                 ex_alu_s = ex_a_s + ex_b_s;
      OP_SUB:                 ex_alu_s = ex_a_s - ex_b_s;
      OP_AND:                 ex_alu_s = ex_a_s & ex_b_s;
      OP_OR:                  ex_alu_s = ex_a_s | ex_b_s;
      OP_SLT:                 ex_alu_s = {31'd0, ($signed(ex_a_s) < $signed(ex_b_s))};
      OP_MUL:                 ex_alu_s = ex_a_s * ex_b_s;
      OP_ADDI, OP_LW, OP_SW:  ex_alu_s = ex_a_s + idex_imm_r;
      OP_SUBI:                ex_alu_s = ex_a_s - idex_imm_r;
      OP_SLTI:                ex_alu_s = {31'd0, ($signed(ex_a_s) < $signed(idex_imm_r))};
      default:                ex_alu_s = 32'd0;
    endcase
    ex_target_s = idex_npc_r + idex_imm_r[AW-1:0];
    if (idex_branch_r && !HALTED) begin
      ex_taken_s = (idex_op_r == OP_BNEQZ) ? (ex_a_s != 32'd0) : (ex_a_s == 32'd0);
    end else begin
      ex_taken_s = 1'b0;
    end
  end

  // Next fetch address: a taken branch overrides stalls and halt parking.
  always_comb begin
    fetch_hold_s = ld_use_s || id_hlt_s || stop_fetch_r;
    if (ex_taken_s) begin
      pc_next_s = ex_target_s;
    end else if (fetch_hold_s) begin
      pc_next_s = PC;
    end else begin
      pc_next_s = PC + PC_INC;
    end
  end

  // Load data is read combinationally in MEM.
  always_comb begin
    if (exmem_memread_r) begin
      mem_data_s = Mem[exmem_alu_r[AW-1:0]];
    end else begin
      mem_data_s = exmem_alu_r;
    end
  end

  // PC and fetch-parking flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= {AW{1'b0}};
      stop_fetch_r <= 1'b0;
    end else if (!HALTED) begin
      PC <= pc_next_s;
      if (ex_taken_s) begin
        stop_fetch_r <= 1'b0;
      end else if (id_hlt_s) begin
        stop_fetch_r <= 1'b1;
      end
    end
  end

  // IF/ID register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid_r <= 1'b0;
      ifid_ir_r    <= 32'd0;
      ifid_npc_r   <= {AW{1'b0}};
    end else if (!HALTED) begin
      if (ex_taken_s || (!ld_use_s && (id_hlt_s || stop_fetch_r))) begin
        ifid_valid_r <= 1'b0;
        ifid_ir_r    <= 32'd0;
      end else if (!ld_use_s) begin
        ifid_valid_r <= 1'b1;
        ifid_ir_r    <= Mem[PC];
        ifid_npc_r   <= PC + PC_INC;
      end
    end
  end

  // ID/EX register; a squash or load-use stall inserts a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_op_r       <= 6'd0;
      idex_rs_r       <= 5'd0;
      idex_rt_r       <= 5'd0;
      idex_dest_r     <= 5'd0;
      idex_a_r        <= 32'd0;
      idex_b_r        <= 32'd0;
      idex_imm_r      <= 32'd0;
      idex_npc_r      <= {AW{1'b0}};
      idex_we_r       <= 1'b0;
      idex_memread_r  <= 1'b0;
      idex_memwrite_r <= 1'b0;
      idex_branch_r   <= 1'b0;
      idex_hlt_r      <= 1'b0;
    end else if (!HALTED) begin
      idex_op_r   <= id_op_s;
      idex_rs_r   <= id_rs_s;
      idex_rt_r   <= id_rt_s;
      idex_a_r    <= id_a_s;
      idex_b_r    <= id_b_s;
      idex_imm_r  <= id_imm_s;
      idex_npc_r  <= ifid_npc_r;
      if (ex_taken_s || ld_use_s) begin
        idex_dest_r     <= 5'd0;
        idex_we_r       <= 1'b0;
        idex_memread_r  <= 1'b0;
        idex_memwrite_r <= 1'b0;
        idex_branch_r   <= 1'b0;
        idex_hlt_r      <= 1'b0;
      end else begin
        idex_dest_r     <= id_dest_s;
        idex_we_r       <= id_we_s;
        idex_memread_r  <= id_memread_s;
        idex_memwrite_r <= id_memwrite_s;
        idex_branch_r   <= id_branch_s;
        idex_hlt_r      <= id_hlt_s;
      end
    end
  end

  // EX/MEM register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_dest_r     <= 5'd0;
      exmem_alu_r      <= 32'd0;
      exmem_b_r        <= 32'd0;
      exmem_we_r       <= 1'b0;
      exmem_memread_r  <= 1'b0;
      exmem_memwrite_r <= 1'b0;
      exmem_hlt_r      <= 1'b0;
    end else if (!HALTED) begin
      exmem_dest_r     <= idex_dest_r;
      exmem_alu_r      <= ex_alu_s;
      exmem_b_r        <= ex_b_s;
      exmem_we_r       <= idex_we_r;
      exmem_memread_r  <= idex_memread_r;
      exmem_memwrite_r <= idex_memwrite_r;
      exmem_hlt_r      <= idex_hlt_r;
    end
  end

  // MEM/WB register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwb_dest_r <= 5'd0;
      memwb_data_r <= 32'd0;
      memwb_we_r   <= 1'b0;
      memwb_hlt_r  <= 1'b0;
    end else if (!HALTED) begin
      memwb_dest_r <= exmem_dest_r;
      memwb_data_r <= mem_data_s;
      memwb_we_r   <= exmem_we_r;
      memwb_hlt_r  <= exmem_hlt_r;
    end
  end

  // Halt flag (sticky until reset) and one-cycle taken-branch flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
    end else begin
      TAKEN_BRANCH <= ex_taken_s;
      if (memwb_hlt_r) begin
        HALTED <= 1'b1;
      end
    end
  end

  // Register file write at the WB edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (wb_we_s) begin
      Reg[memwb_dest_r] <= memwb_data_r;
    end
  end

  // Store at the MEM edge; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (exmem_memwrite_r && !HALTED) begin
      Mem[exmem_alu_r[AW-1:0]] <= exmem_b_r;
    end
  end

endmodule

// File: tb/tb_pipe_mips32.sv
// Directed bench for pipe_mips32: loads small programs through hierarchy,
// runs each to HLT and compares registers, memory and flags with
// hand-computed values.
module tb_pipe_mips32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic halted;

  pipe_mips32 #(.MEM_WORDS(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .halted(halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int taken_cnt;
  logic [31:0] prog [$];

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hold reset, clear memory, load the program and Reg[k]=k.
  task automatic reset_load();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) dut.Mem[i[9:0]] = 32'h0;
    for (int i = 0; i < prog.size(); i++) dut.Mem[i[9:0]] = prog[i];
    for (int k = 0; k < 32; k++) dut.Reg[k[4:0]] = k;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_halt(input int budget);
    int cyc;
    cyc = 0;
    taken_cnt = 0;
    while (halted !== 1'b1 && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (dut.TAKEN_BRANCH === 1'b1) taken_cnt++;
    end
    check32("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #2;
    check32("rst_pc", {22'd0, dut.PC}, 32'd0);
    check32("rst_halted_flag", {31'd0, dut.HALTED}, 32'd0);
    check32("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    check32("rst_halted_port", {31'd0, halted}, 32'd0);

    // Basic program with independent and chained ops
    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
             32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    reset_load();
    release_rst();
    run_until_halt(200);
    check32("t1_r0", dut.Reg[0], 32'd0);
    check32("t1_r1", dut.Reg[1], 32'd10);
    check32("t1_r2", dut.Reg[2], 32'd20);
    check32("t1_r3", dut.Reg[3], 32'd25);
    check32("t1_r4", dut.Reg[4], 32'd30);
    check32("t1_r5", dut.Reg[5], 32'd55);
    check32("t1_r15", dut.Reg[15], 32'd7);

    // Back-to-back dependencies through forwarding
    prog = '{32'h28010005, 32'h00211000, 32'h00411800, 32'hfc000000};
    reset_load();
    release_rst();
    run_until_halt(200);
    check32("fwd_r2", dut.Reg[2], 32'd10);
    check32("fwd_r3", dut.Reg[3], 32'd15);

    // Load-use stall and forwarded store data
    prog = '{32'h28010064, 32'h20220000, 32'h00421800, 32'h24230001, 32'hfc000000};
    reset_load();
    dut.Mem[100] = 32'd77;
    release_rst();
    run_until_halt(200);
    check32("ld_r2", dut.Reg[2], 32'd77);
    check32("ld_r3", dut.Reg[3], 32'd154);
    check32("ld_mem101", dut.Mem[101], 32'd154);

    // Branch loop: taken twice, younger HLT squashed each time
    prog = '{32'h28010003, 32'h28020000, 32'h28420002, 32'h2c210001, 32'h3420fffd, 32'hfc000000};
    reset_load();
    release_rst();
    run_until_halt(300);
    check32("br_r1", dut.Reg[1], 32'd0);
    check32("br_r2", dut.Reg[2], 32'd6);
    check32("br_taken_cnt", taken_cnt, 32'd2);

    // Remaining ALU ops, SLTI with negative imm, BEQZ skipping one instruction
    prog = '{32'h04655000, 32'h08c75800, 32'h11416000, 32'h14c76800, 32'h314effff,
             32'h38000001, 32'h28100063, 32'hfc000000};
    reset_load();
    release_rst();
    run_until_halt(200);
    check32("alu_sub", dut.Reg[10], 32'hfffffffe);
    check32("alu_and", dut.Reg[11], 32'd6);
    check32("alu_slt", dut.Reg[12], 32'd1);
    check32("alu_mul", dut.Reg[13], 32'd42);
    check32("alu_slti", dut.Reg[14], 32'd1);
    check32("beqz_skip_r16", dut.Reg[16], 32'd16);
    check32("beqz_taken_cnt", taken_cnt, 32'd1);

    // Halt freeze: nothing after HLT may execute
    prog = '{32'h28080007, 32'hfc000000, 32'h28090001};
    reset_load();
    release_rst();
    run_until_halt(200);
    check32("hf_r8", dut.Reg[8], 32'd7);
    check32("hf_pc_at_halt", {22'd0, dut.PC}, 32'd2);
    repeat (10) @(posedge clk);
    #1;
    check32("hf_pc_frozen", {22'd0, dut.PC}, 32'd2);
    check32("hf_r9", dut.Reg[9], 32'd9);
    check32("hf_halted", {31'd0, halted}, 32'd1);

    // Mid-run reset: flush pipeline, keep architectural state, rerun
    prog = '{32'h28010005, 32'h00211000, 32'h00411800, 32'hfc000000};
    reset_load();
    release_rst();
    repeat (5) @(posedge clk);
    #1;
    check32("mr_r1_before", dut.Reg[1], 32'd5);
    check32("mr_r2_before", dut.Reg[2], 32'd2);
    rst_n = 1'b0;
    #1;
    check32("mr_pc", {22'd0, dut.PC}, 32'd0);
    check32("mr_halted", {31'd0, dut.HALTED}, 32'd0);
    check32("mr_ifid_empty", {31'd0, dut.ifid_valid_r}, 32'd0);
    check32("mr_idex_empty", {31'd0, dut.idex_we_r}, 32'd0);
    check32("mr_exmem_empty", {31'd0, dut.exmem_we_r}, 32'd0);
    check32("mr_memwb_empty", {31'd0, dut.memwb_we_r}, 32'd0);
    check32("mr_r1_kept", dut.Reg[1], 32'd5);
    check32("mr_mem0_kept", dut.Mem[0], 32'h28010005);
    release_rst();
    run_until_halt(200);
    check32("mr_rerun_r2", dut.Reg[2], 32'd10);
    check32("mr_rerun_r3", dut.Reg[3], 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
